// File: rtl/westminster_clock_pkg.sv
// Shared constants, sequencer state type and BCD helpers for the
// Westminster chime clock.
package westminster_clock_pkg;

  // BCD limits for the seconds/minutes counters and the 12-hour dial
  localparam logic [7:0] BCD_SEC_MIN_MAX = 8'h59;
  localparam logic [7:0] BCD_HOUR_MAX    = 8'h12;
  localparam logic [7:0] BCD_HOUR_MIN    = 8'h01;
  localparam logic [7:0] BCD_HOUR_ELEVEN = 8'h11;

  // Notes per quarter-hour phrase
  localparam logic [4:0] NOTES_Q15 = 5'd4;
  localparam logic [4:0] NOTES_Q30 = 5'd8;
  localparam logic [4:0] NOTES_Q45 = 5'd12;
  localparam logic [4:0] NOTES_Q00 = 5'd16;

  // Silent gap between the hourly phrase and the strikes, in ticks
  localparam logic [5:0] REST_LEN = 6'd2;

  // Chime sequencer states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PHRASE = 2'd1,
    ST_REST   = 2'd2,
    ST_STRIKE = 2'd3
  } chime_state_t;

  // Increment a two-digit BCD value (caller handles the wrap limit)
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Convert a BCD hour (01..12) to binary 1..12; tens digit is 0 or 1
  function automatic logic [3:0] bcd_hour_to_bin(input logic [7:0] b);
    return b[3:0] + (b[4] ? 4'd10 : 4'd0);
  endfunction

endpackage

// File: rtl/westminster_clock_bcd_counter.sv
// Two-digit BCD counter 00..MAX with enable and a carry-out that is
// high on the enabled cycle in which the counter wraps to 00.
// o_next is the value the counter will hold after this edge.
module bcd_counter
  import westminster_clock_pkg::*;
#(
  parameter logic [7:0] MAX = BCD_SEC_MIN_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  output logic [7:0] o_count,
  output logic [7:0] o_next,
  output logic       o_carry
);

  logic [7:0] r_count;
  logic       w_at_max;

  assign w_at_max = (r_count == MAX);
  assign o_carry  = i_en & w_at_max;
  assign o_next   = !i_en    ? r_count :
                    w_at_max ? 8'h00   : bcd_inc(r_count);
  assign o_count  = r_count;

  // Counter register: clears on reset, otherwise loads the next value
  always_ff @(posedge clk) begin
    if (reset) r_count <= 8'h00;
    else       r_count <= o_next;
  end

endmodule

// File: rtl/westminster_clock.sv
// 12-hour BCD wall clock with AM/PM and a Westminster chime sequencer.
// Quarter hours play 4/8/12 notes; the hour plays 16 notes, a 2-tick
// rest, then one strike per hour. Each note/strike is one tick high and
// one tick low. Everything advances only on ena ticks.
// Sequencer state is held in r_state (chime_state_t) for observation.
module westminster_clock
  import westminster_clock_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  output logic       pm,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       chime
);

  logic [7:0] w_ss, w_ss_next;
  logic       w_ss_carry;
  logic [7:0] w_mm, w_mm_next;
  logic       w_mm_carry;

  logic [7:0] r_hh;
  logic       r_pm;
  logic [7:0] w_hh_next;
  logic       w_pm_next;

  logic       w_quarter;
  logic       w_trigger;
  logic       w_top;
  logic [4:0] w_notes;
  logic [5:0] w_phrase_len;
  logic [5:0] w_strike_len;

  chime_state_t r_state;
  logic [5:0]   r_step;
  logic [5:0]   r_phrase_len;
  logic [5:0]   r_strike_len;
  logic         r_top;
  logic         r_chime;
  logic [5:0]   w_step_inc;

  bcd_counter #(.MAX(BCD_SEC_MIN_MAX)) u_sec (
    .clk     (clk),
    .reset   (reset),
    .i_en    (ena),
    .o_count (w_ss),
    .o_next  (w_ss_next),
    .o_carry (w_ss_carry)
  );

  bcd_counter #(.MAX(BCD_SEC_MIN_MAX)) u_min (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_ss_carry),
    .o_count (w_mm),
    .o_next  (w_mm_next),
    .o_carry (w_mm_carry)
  );

  // Next hour and meridiem: 12 wraps to 01, 11 -> 12 flips AM/PM
  always_comb begin
    w_hh_next = r_hh;
    w_pm_next = r_pm;
    if (w_mm_carry) begin
      case (r_hh)
        BCD_HOUR_MAX:    w_hh_next = BCD_HOUR_MIN;
        BCD_HOUR_ELEVEN: begin
          w_hh_next = BCD_HOUR_MAX;
          w_pm_next = ~r_pm;
        end
        default:         w_hh_next = bcd_inc(r_hh);
      endcase
    end
  end

  // Hour and meridiem registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hh <= BCD_HOUR_MAX;
      r_pm <= 1'b0;
    end else begin
      r_hh <= w_hh_next;
      r_pm <= w_pm_next;
    end
  end

  // Trigger decode from the time about to be shown: ss = 00 on a tick
  // and minutes on a quarter. Phrase length is chosen by the new minute.
  always_comb begin
    w_quarter = 1'b1;
    w_notes   = NOTES_Q00;
    case (w_mm_next)
      8'h00:   w_notes = NOTES_Q00;
      8'h15:   w_notes = NOTES_Q15;
      8'h30:   w_notes = NOTES_Q30;
      8'h45:   w_notes = NOTES_Q45;
      default: w_quarter = 1'b0;
    endcase
  end

  assign w_trigger    = ena && (w_ss_next == 8'h00) && w_quarter;
  assign w_top        = (w_mm_next == 8'h00);
  assign w_phrase_len = {w_notes, 1'b0};
  assign w_strike_len = {1'b0, bcd_hour_to_bin(w_hh_next), 1'b0};
  assign w_step_inc   = r_step + 6'd1;

  // Chime sequencer: a new trigger always restarts at step 0; chime is
  // high on even steps of PHRASE/STRIKE and low in REST/IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_step       <= 6'd0;
      r_phrase_len <= 6'd0;
      r_strike_len <= 6'd0;
      r_top        <= 1'b0;
      r_chime      <= 1'b0;
    end else if (ena) begin
      if (w_trigger) begin
        r_state      <= ST_PHRASE;
        r_step       <= 6'd0;
        r_phrase_len <= w_phrase_len;
        r_strike_len <= w_strike_len;
        r_top        <= w_top;
        r_chime      <= 1'b1;
      end else begin
        case (r_state)
          ST_PHRASE: begin
            if (r_step == r_phrase_len - 6'd1) begin
              r_state <= r_top ? ST_REST : ST_IDLE;
              r_step  <= 6'd0;
              r_chime <= 1'b0;
            end else begin
              r_step  <= w_step_inc;
              r_chime <= ~w_step_inc[0];
            end
          end
          ST_REST: begin
            if (r_step == REST_LEN - 6'd1) begin
              r_state <= ST_STRIKE;
              r_step  <= 6'd0;
              r_chime <= 1'b1;
            end else begin
              r_step  <= w_step_inc;
              r_chime <= 1'b0;
            end
          end
          ST_STRIKE: begin
            if (r_step == r_strike_len - 6'd1) begin
              r_state <= ST_IDLE;
              r_step  <= 6'd0;
              r_chime <= 1'b0;
            end else begin
              r_step  <= w_step_inc;
              r_chime <= ~w_step_inc[0];
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_step  <= 6'd0;
            r_chime <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pm    = r_pm;
  assign hh    = r_hh;
  assign mm    = w_mm;
  assign ss    = w_ss;
  assign chime = r_chime;

endmodule

// File: tb/tb_westminster_clock.sv
// Bench for westminster_clock. The reference keeps time as seconds since
// 12:00:00 AM and the chime as a queue of expected bits built from the
// phrase/rest/strike rules whenever a new time lands on a quarter hour.
module tb_westminster_clock;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ena = 1'b0;
  logic       pm, chime;
  logic [7:0] hh, mm, ss;

  always #5 clk = ~clk;

  westminster_clock dut (
    .clk   (clk),
    .reset (reset),
    .ena   (ena),
    .pm    (pm),
    .hh    (hh),
    .mm    (mm),
    .ss    (ss),
    .chime (chime)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int         t = 0;            // seconds since midnight, 0..86399
  logic [0:0] exp_q[$];         // pending chime bits, front = next tick
  logic       exp_chime = 1'b0;

  logic [24:0] got;
  assign got = {pm, hh, mm, ss, chime};

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic int hour12();
    int h;
    h = (t / 3600) % 12;
    return (h == 0) ? 12 : h;
  endfunction

  function automatic logic [24:0] exp_vec();
    logic p;
    p = (t >= 12 * 3600);
    return {p, to_bcd(hour12()), to_bcd((t / 60) % 60), to_bcd(t % 60), exp_chime};
  endfunction

  function automatic void model_tick();
    int m;
    t = (t + 1) % 86400;
    m = (t / 60) % 60;
    if ((t % 60 == 0) && (m % 15 == 0)) begin
      int notes;
      exp_q.delete();
      notes = (m == 0) ? 16 : (m / 15) * 4;
      for (int i = 0; i < notes; i++) begin
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
      end
      if (m == 0) begin
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b0);
        for (int i = 0; i < hour12(); i++) begin
          exp_q.push_back(1'b1);
          exp_q.push_back(1'b0);
        end
      end
    end
    exp_chime = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    ena   = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    reset = 1'b0;
    ena   = 1'b0;
    t = 0;
    exp_q.delete();
    exp_chime = 1'b0;
  endtask

  task automatic tick(input logic en);
    ena = en;
    @(posedge clk);
    #1;
    ena = 1'b0;
    if (en) model_tick();
  endtask

  task automatic run_to(input int target);
    int guard;
    guard = 0;
    while (t != target && guard < 90000) begin
      tick(1'b1);
      guard++;
    end
    checks++;
    if (t != target) begin
      errors++;
      $display("FAIL run_to: reached t=%0d, required t=%0d", t, target);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (got !== {1'b0, 8'h12, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got %h, required %h", got, {1'b0, 8'h12, 8'h00, 8'h00, 1'b0});
    end
    tick(1'b1);
    checks++;
    if (ss !== 8'h01) begin
      errors++;
      $display("FAIL first_tick_ss: got %h, required 01", ss);
    end
    checks++;
    if (got !== exp_vec()) begin
      errors++;
      $display("FAIL first_tick_vec: got %h, required %h", got, exp_vec());
    end
  endtask

  task automatic test_quarter();
    run_to(14 * 60 + 59);
    checks++;
    if (got !== exp_vec()) begin
      errors++;
      $display("FAIL quarter_pre: got %h, required %h", got, exp_vec());
    end
    tick(1'b1);
    checks++;
    if ({pm, hh, mm, ss} !== {1'b0, 8'h12, 8'h15, 8'h00}) begin
      errors++;
      $display("FAIL quarter_time: got %h, required 0121500", {pm, hh, mm, ss});
    end
    for (int k = 0; k < 10; k++) begin
      logic want;
      if (k > 0) tick(1'b1);
      want = (k < 8) ? ((k % 2) == 0) : 1'b0;
      checks++;
      if (chime !== want) begin
        errors++;
        $display("FAIL quarter_chime k=%0d: got %b, required %b", k, chime, want);
      end
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL quarter_vec k=%0d: got %h, required %h", k, got, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_chime();
    run_to(30 * 60);
    for (int k = 0; k < 5; k++) tick(1'b1);
    checks++;
    if (got !== exp_vec()) begin
      errors++;
      $display("FAIL mid_chime_step5: got %h, required %h", got, exp_vec());
    end
    do_reset();
    checks++;
    if (got !== {1'b0, 8'h12, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL mid_chime_reset: got %h, required %h", got, {1'b0, 8'h12, 8'h00, 8'h00, 1'b0});
    end
    for (int k = 0; k < 20; k++) begin
      tick(1'($urandom_range(0, 1)));
      checks++;
      if (chime !== 1'b0 || got !== exp_vec()) begin
        errors++;
        $display("FAIL after_reset k=%0d: got %h, required %h", k, got, exp_vec());
      end
    end
  endtask

  task automatic test_ena_gating();
    run_to(15 * 60 + 2);
    for (int k = 0; k < 10; k++) begin
      tick(1'b0);
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL gated k=%0d: got %h, required %h", k, got, exp_vec());
      end
    end
    for (int k = 0; k < 8; k++) begin
      tick(1'b1);
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL resume k=%0d: got %h, required %h", k, got, exp_vec());
      end
    end
    // random ena across the :30 phrase
    run_to(29 * 60 + 55);
    for (int k = 0; k < 300; k++) begin
      tick(1'($urandom_range(0, 1)));
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL random_ena k=%0d: got %h, required %h", k, got, exp_vec());
      end
    end
  endtask

  task automatic test_top_of_hour(input int start, input logic [24:0] first, input int highs);
    int n_high;
    run_to(start);
    tick(1'b1);
    checks++;
    if (got !== first) begin
      errors++;
      $display("FAIL hour_first: got %h, required %h", got, first);
    end
    n_high = (chime === 1'b1) ? 1 : 0;
    for (int k = 1; k < 64; k++) begin
      tick(1'b1);
      if (chime === 1'b1) n_high++;
      checks++;
      if (got !== exp_vec()) begin
        errors++;
        $display("FAIL hour_seq k=%0d: got %h, required %h", k, got, exp_vec());
      end
    end
    checks++;
    if (n_high != highs) begin
      errors++;
      $display("FAIL hour_high_count: got %0d, required %0d", n_high, highs);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_quarter();
    test_reset_mid_chime();
    test_ena_gating();
    // noon: 16 notes + 12 strikes
    test_top_of_hour(11 * 3600 + 59 * 60 + 59, {1'b1, 8'h12, 8'h00, 8'h00, 1'b1}, 28);
    // 12 PM -> 1 PM: 16 notes + 1 strike
    test_top_of_hour(12 * 3600 + 59 * 60 + 59, {1'b1, 8'h01, 8'h00, 8'h00, 1'b1}, 17);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
